temp_bcd_converter: RTL and testbench

//  Downstream stage of the I2C temperature master. Consumes each 8-bit signed Celsius byte
//  (temp_data + 1-cycle temp_valid strobe per completed sensor read), averages 2**AVG_LOG2

---
 rtl/temp_bcd_converter_if.sv | 29 ++
 rtl/temp_bcd_converter.sv | 230 +++++++++++++++++++++++
 tb/tb_temp_bcd_converter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/temp_bcd_converter_if.sv
`timescale 1ns/1ps
// temp_bcd_converter_if: sample stream into the converter and BCD display bus out of it.
// Signals: temp_data/temp_valid/temp_ready (sample handshake),
//   bcd_sign/bcd_hund/bcd_tens/bcd_ones/bcd_valid (result), unit_f, overrun.
// Modports: master = sample producer / display side, slave = converter.
interface temp_bcd_converter_if;
   logic [7:0] temp_data;
   logic       temp_valid;
   logic       temp_ready;
   logic       bcd_sign;
   logic [3:0] bcd_hund;
   logic [3:0] bcd_tens;
   logic [3:0] bcd_ones;
   logic       bcd_valid;
   logic       unit_f;
   logic       overrun;

   modport master (
      output temp_data, temp_valid,
      input  temp_ready, bcd_sign, bcd_hund, bcd_tens,
      input  bcd_ones, bcd_valid, unit_f, overrun
   );

   modport slave (
      input  temp_data, temp_valid,
      output temp_ready, bcd_sign, bcd_hund, bcd_tens,
      output bcd_ones, bcd_valid, unit_f, overrun
   );
endinterface

// File: rtl/temp_bcd_converter.sv
`timescale 1ns/1ps
// temp_bcd_converter: averages 2**AVG_LOG2 signed Celsius samples and emits
// sign + 3 BCD digits with a 1-cycle bcd_valid pulse.
// Ports: clk_200kHz (clock), reset (async, active-low),
//   bus (slave): temp_data/temp_valid in; temp_ready, bcd_sign, bcd_hund,
//   bcd_tens, bcd_ones, bcd_valid, unit_f, overrun out.
// Build option: define TEMP_FAHRENHEIT_EN to convert the average to Fahrenheit.
module temp_bcd_converter #(
   parameter int AVG_LOG2 = 2
) (
   input  logic                 clk_200kHz,
   input  logic                 reset,
   temp_bcd_converter_if.slave  bus
);
   localparam int AW = 8 + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

   typedef enum logic [2:0] {
      IDLE, AVG, SIGN, FCONV, BCD, DONE
   } state_t;

   state_t               state_q, state_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic signed [7:0]    avg_q, avg_d;
   logic                 sign_q, sign_d;
   logic [8:0]           mag_q, mag_d;
   logic [20:0]          sh_q, sh_d;
   logic [3:0]           cyc_q, cyc_d;
   logic [3:0]           hund_q, hund_d;
   logic [3:0]           tens_q, tens_d;
   logic [3:0]           ones_q, ones_d;
   logic                 osign_q, osign_d;
   logic                 bvalid_q, bvalid_d;
   logic                 ovr_q, ovr_d;

   logic signed [7:0]    sample;
   logic signed [AW-1:0] avg_full;
   logic signed [8:0]    avg9;
   logic [8:0]           mag_c;

   assign sample   = bus.temp_data;
   assign avg_full = acc_q >>> AVG_LOG2;
   assign avg9     = {avg_q[7], avg_q};
   assign mag_c    = avg_q[7] ? -avg9 : avg9;

   // double-dabble: add-3 on digits >= 5, then shift one bit in
   logic [3:0]  dh, dt, dn;
   logic [20:0] dd_fix, dd_next;

   always_comb begin
      dh = sh_q[20:17];
      dt = sh_q[16:13];
      dn = sh_q[12:9];
      if (dh >= 4'd5) dh = dh + 4'd3;
      if (dt >= 4'd5) dt = dt + 4'd3;
      if (dn >= 4'd5) dn = dn + 4'd3;
      dd_fix  = {dh, dt, dn, sh_q[8:0]};
      dd_next = {dd_fix[19:0], 1'b0};
   end

`ifdef TEMP_FAHRENHEIT_EN
   // |C|*9 then restoring divide by 5, one quotient bit per cycle
   logic [10:0]       quo_q, quo_d;
   logic [2:0]        rem_q, rem_d;
   logic [3:0]        rem_sh;
   logic [2:0]        div_rem;
   logic [10:0]       div_quo;
   logic [10:0]       x9;
   logic [9:0]        q10;
   logic signed [9:0] f_val;
   logic [8:0]        f_mag;

   always_comb begin
      x9     = 11'({mag_q, 3'b000}) + 11'(mag_q);
      rem_sh = {rem_q, quo_q[10]};
      if (rem_sh >= 4'd5) begin
         div_rem = 3'(rem_sh - 4'd5);
         div_quo = {quo_q[9:0], 1'b1};
      end else begin
         div_rem = rem_sh[2:0];
         div_quo = {quo_q[9:0], 1'b0};
      end
      q10   = 10'(div_quo);
      // truncation toward zero: divide the magnitude, then reapply sign
      f_val = sign_q ? 10'sd32 - $signed(q10)
                     : 10'sd32 + $signed(q10);
      f_mag = f_val[9] ? 9'(-f_val) : f_val[8:0];
   end
`endif

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      avg_d    = avg_q;
      sign_d   = sign_q;
      mag_d    = mag_q;
      sh_d     = sh_q;
      cyc_d    = cyc_q;
      hund_d   = hund_q;
      tens_d   = tens_q;
      ones_d   = ones_q;
      osign_d  = osign_q;
      bvalid_d = 1'b0;
      ovr_d    = ovr_q | (bus.temp_valid & (state_q != IDLE));
`ifdef TEMP_FAHRENHEIT_EN
      quo_d    = quo_q;
      rem_d    = rem_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.temp_valid) begin
               acc_d = acc_q + AW'(sample);
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) state_d = AVG;
            end
         end
         AVG: begin
            avg_d   = 8'(avg_full);
            acc_d   = '0;
            cnt_d   = '0;
            state_d = SIGN;
         end
         SIGN: begin
            sign_d = avg_q[7];
            mag_d  = mag_c;
            cyc_d  = '0;
`ifdef TEMP_FAHRENHEIT_EN
            state_d = FCONV;
`else
            sh_d    = {12'd0, mag_c};
            state_d = BCD;
`endif
         end
`ifdef TEMP_FAHRENHEIT_EN
         FCONV: begin
            cyc_d = cyc_q + 4'd1;
            if (cyc_q == 4'd0) begin
               quo_d = x9;
               rem_d = '0;
            end else begin
               quo_d = div_quo;
               rem_d = div_rem;
            end
            if (cyc_q == 4'd11) begin
               sign_d  = f_val[9];
               mag_d   = f_mag;
               sh_d    = {12'd0, f_mag};
               cyc_d   = '0;
               state_d = BCD;
            end
         end
`endif
         BCD: begin
            sh_d  = dd_next;
            cyc_d = cyc_q + 4'd1;
            if (cyc_q == 4'd8) begin
               cyc_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            hund_d   = sh_q[20:17];
            tens_d   = sh_q[16:13];
            ones_d   = sh_q[12:9];
            osign_d  = sign_q & (mag_q != 9'd0);
            bvalid_d = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_200kHz or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         avg_q    <= '0;
         sign_q   <= 1'b0;
         mag_q    <= '0;
         sh_q     <= '0;
         cyc_q    <= '0;
         hund_q   <= '0;
         tens_q   <= '0;
         ones_q   <= '0;
         osign_q  <= 1'b0;
         bvalid_q <= 1'b0;
         ovr_q    <= 1'b0;
`ifdef TEMP_FAHRENHEIT_EN
         quo_q    <= '0;
         rem_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         avg_q    <= avg_d;
         sign_q   <= sign_d;
         mag_q    <= mag_d;
         sh_q     <= sh_d;
         cyc_q    <= cyc_d;
         hund_q   <= hund_d;
         tens_q   <= tens_d;
         ones_q   <= ones_d;
         osign_q  <= osign_d;
         bvalid_q <= bvalid_d;
         ovr_q    <= ovr_d;
`ifdef TEMP_FAHRENHEIT_EN
         quo_q    <= quo_d;
         rem_q    <= rem_d;
`endif
      end
   end

   assign bus.temp_ready = (state_q == IDLE);
   assign bus.bcd_sign   = osign_q;
   assign bus.bcd_hund   = hund_q;
   assign bus.bcd_tens   = tens_q;
   assign bus.bcd_ones   = ones_q;
   assign bus.bcd_valid  = bvalid_q;
   assign bus.overrun    = ovr_q;
`ifdef TEMP_FAHRENHEIT_EN
   assign bus.unit_f     = 1'b1;
`else
   assign bus.unit_f     = 1'b0;
`endif
endmodule

// File: tb/tb_temp_bcd_converter.sv
`timescale 1ns/1ps
// tb_temp_bcd_converter: directed vectors, scoreboard queue of expected
// results popped by a monitor on every bcd_valid pulse.
module tb_temp_bcd_converter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   temp_bcd_converter_if bus();

   temp_bcd_converter #(.AVG_LOG2(2)) dut (
      .clk_200kHz (clk),
      .reset      (rst_n),
      .bus        (bus)
   );

`ifdef TEMP_FAHRENHEIT_EN
   localparam int   LAT  = 24;
   localparam logic UNIT = 1'b1;
`else
   localparam int   LAT  = 12;
   localparam logic UNIT = 1'b0;
`endif

   typedef struct {
      logic [12:0] val;
      int          edge_no;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   edge_cnt = 0;
   int   last_cap = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic logic [12:0] r(input bit s, input int h, t, o);
      return {s, 4'(h), 4'(t), 4'(o)};
   endfunction

   function automatic logic [12:0] outs();
      return {bus.bcd_sign, bus.bcd_hund, bus.bcd_tens, bus.bcd_ones};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (bus.bcd_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious_bcd_valid", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("result", 32'(outs()), 32'(mon_e.val));
            chk("latency", edge_cnt, mon_e.edge_no);
         end
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      bus.temp_valid = 1'b1;
      bus.temp_data  = b;
      @(negedge clk);
      bus.temp_valid = 1'b0;
      last_cap       = edge_cnt;
   endtask

   task automatic run4(input logic [7:0] a, b, c, d,
                       input logic [12:0] e, input bit push);
      exp_t x;
      send(a);
      send(b);
      send(c);
      send(d);
      if (push) begin
         x.val     = e;
         x.edge_no = last_cap + LAT;
         sb.push_back(x);
      end
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (sb.size() != 0 && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         chk({name, "_timeout"}, 32'(sb.size()), 32'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   logic [12:0] e25, em2, em128, e127, em18, e11, e0;

   initial begin
      bus.temp_valid = 1'b0;
      bus.temp_data  = 8'h00;
`ifdef TEMP_FAHRENHEIT_EN
      e25 = r(0,0,7,7);  em2 = r(0,0,2,9); em128 = r(1,1,9,8);
      e127 = r(0,2,6,0); em18 = r(0,0,0,0); e11 = r(0,0,5,1);
      e0 = r(0,0,3,2);
`else
      e25 = r(0,0,2,5);  em2 = r(1,0,0,2); em128 = r(1,1,2,8);
      e127 = r(0,1,2,7); em18 = r(1,0,1,8); e11 = r(0,0,1,1);
      e0 = r(0,0,0,0);
`endif

      // reset
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_outs", 32'(outs()), 32'd0);
      chk("reset_valid", bus.bcd_valid, 1'b0);
      chk("reset_ready", bus.temp_ready, 1'b1);
      chk("reset_overrun", bus.overrun, 1'b0);
      chk("unit_f", bus.unit_f, UNIT);

      // averaging and sign/magnitude cases
      run4(8'h19, 8'h19, 8'h1A, 8'h1A, e25, 1'b1);
      drain("avg25");
      repeat (5) @(negedge clk);
      chk("hold", 32'(outs()), 32'(e25));
      run4(8'hFF, 8'hFE, 8'hFE, 8'hFE, em2, 1'b1);
      drain("avg_m2");
      run4(8'h80, 8'h80, 8'h80, 8'h80, em128, 1'b1);
      drain("avg_m128");
      run4(8'h7F, 8'h7F, 8'h7F, 8'h7F, e127, 1'b1);
      drain("avg127");
      run4(8'hEE, 8'hEE, 8'hEE, 8'hEE, em18, 1'b1);
      drain("avg_m18");

      // overrun while busy
      run4(8'h19, 8'h19, 8'h19, 8'h19, e25, 1'b1);
      repeat (4) @(negedge clk);
      chk("busy_ready", bus.temp_ready, 1'b0);
      chk("overrun_pre", bus.overrun, 1'b0);
      bus.temp_valid = 1'b1;
      bus.temp_data  = 8'h63;
      @(negedge clk);
      bus.temp_valid = 1'b0;
      chk("overrun_set", bus.overrun, 1'b1);
      drain("ovr_pending");
      run4(8'h0A, 8'h0B, 8'h0C, 8'h0D, e11, 1'b1);
      drain("after_ovr");
      chk("overrun_sticky", bus.overrun, 1'b1);

      // reset mid-conversion
      run4(8'h05, 8'h05, 8'h05, 8'h05, 13'd0, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset_outs", 32'(outs()), 32'd0);
      chk("midreset_overrun", bus.overrun, 1'b0);
      chk("midreset_ready", bus.temp_ready, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      run4(8'h00, 8'h00, 8'h00, 8'h00, e0, 1'b1);
      drain("zero");
      chk("unit_f_end", bus.unit_f, UNIT);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
